// File: rtl/i2c_reg_pkg.sv
// Shared types and defaults for the I2C register-file arbiter.
package i2c_reg_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_I2C  = 1'b0,
    REQ_HOST = 1'b1
  } req_id_t;

  function automatic req_id_t other_req(input req_id_t id);
    return (id == REQ_I2C) ? REQ_HOST : REQ_I2C;
  endfunction

endpackage

// File: rtl/i2c_req_capture.sv
// One-deep pending slot turning I2C slave strobes into a held request, with sticky overflow.
module i2c_req_capture #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic              i2c_wen,
  input  logic              i2c_ren,
  input  logic [ADDR_W-1:0] i2c_addr,
  input  logic [DATA_W-1:0] i2c_wdata,
  input  logic              free,
  output logic              pend_valid,
  output logic              pend_we,
  output logic [ADDR_W-1:0] pend_addr,
  output logic [DATA_W-1:0] pend_wdata,
  output logic              ovf
);

  logic              slot_full;
  logic              slot_we;
  logic [ADDR_W-1:0] slot_addr;
  logic [DATA_W-1:0] slot_wdata;
  logic              pulse;
  logic              accept;

  assign pulse  = i2c_wen | i2c_ren;
  assign accept = pulse & (~slot_full | free);

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_full  <= 1'b0;
      slot_we    <= 1'b0;
      slot_addr  <= '0;
      slot_wdata <= '0;
      ovf        <= 1'b0;
    end else begin
      if (accept) begin
        slot_full  <= 1'b1;
        slot_we    <= i2c_wen;
        slot_addr  <= i2c_addr;
        slot_wdata <= i2c_wdata;
      end else if (free) begin
        slot_full  <= 1'b0;
      end
      if ((pulse && !accept) || (i2c_wen && i2c_ren)) begin
        ovf <= 1'b1;
      end
    end
  end

  // A pulse on an empty slot is offered to the arbiter in the same cycle it is latched.
  always_comb begin
    pend_valid = slot_full | pulse;
    pend_we    = slot_we;
    pend_addr  = slot_addr;
    pend_wdata = slot_wdata;
    if (!slot_full) begin
      pend_we    = i2c_wen;
      pend_addr  = i2c_addr;
      pend_wdata = i2c_wdata;
    end
  end

endmodule

// File: rtl/i2c_reg_arbiter.sv
// Serialises I2C-slave and local-host accesses onto one register file.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise I2C has fixed priority.
module i2c_reg_arbiter
  import i2c_reg_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic              i2c_wen,
  input  logic              i2c_ren,
  input  logic [ADDR_W-1:0] i2c_addr,
  input  logic [DATA_W-1:0] i2c_wdata,
  output logic [DATA_W-1:0] i2c_rdata,
  output logic              i2c_rvalid,
  output logic              i2c_ovf,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              addr_err,
  output logic              reg_wen,
  output logic              reg_ren,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata
);

  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(NUM_REGS);
  localparam int unsigned     WAIT_LOAD  = (RD_LAT > 1) ? RD_LAT - 2 : 0;

  arb_state_t        state, state_nxt;
  req_id_t           owner, winner;
  logic              grant;
  logic              op_we, op_oor;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic [1:0]        wait_cnt;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              pend_valid, pend_we, free;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_wdata;

  logic [DATA_W-1:0] rd_value, i2c_rdata_q, host_rdata_q;
  logic              resp_i2c_rd, resp_host, resp_host_rd;

  i2c_req_capture #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_capture (
    .sys_clk    (sys_clk),
    .reset_n    (reset_n),
    .i2c_wen    (i2c_wen),
    .i2c_ren    (i2c_ren),
    .i2c_addr   (i2c_addr),
    .i2c_wdata  (i2c_wdata),
    .free       (free),
    .pend_valid (pend_valid),
    .pend_we    (pend_we),
    .pend_addr  (pend_addr),
    .pend_wdata (pend_wdata),
    .ovf        (i2c_ovf)
  );

`ifdef ARB_RR_EN
  req_id_t rr_prio;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_prio <= REQ_I2C;
    end else if (grant) begin
      rr_prio <= other_req(winner);
    end
  end
`endif

  always_comb begin
    winner = REQ_I2C;
`ifdef ARB_RR_EN
    if (host_req && (!pend_valid || rr_prio == REQ_HOST)) winner = REQ_HOST;
`else
    if (host_req && !pend_valid) winner = REQ_HOST;
`endif
    grant     = (state == ST_IDLE) && (pend_valid || host_req);
    sel_we    = pend_we;
    sel_addr  = pend_addr;
    sel_wdata = pend_wdata;
    if (winner == REQ_HOST) begin
      sel_we    = host_we;
      sel_addr  = host_addr;
      sel_wdata = host_wdata;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (grant) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = (!op_we && RD_LAT > 1) ? ST_WAIT : ST_RESP;
      ST_WAIT:  if (wait_cnt == '0) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      owner        <= REQ_I2C;
      op_we        <= 1'b0;
      op_oor       <= 1'b0;
      op_addr      <= '0;
      op_wdata     <= '0;
      wait_cnt     <= '0;
      i2c_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner    <= winner;
        op_we    <= sel_we;
        op_addr  <= sel_addr;
        op_wdata <= sel_wdata;
        op_oor   <= ({1'b0, sel_addr} >= ADDR_LIMIT);
      end
      if (state == ST_ISSUE) begin
        wait_cnt <= 2'(WAIT_LOAD);
      end else if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt - 2'd1;
      end
      if (resp_i2c_rd)  i2c_rdata_q  <= rd_value;
      if (resp_host_rd) host_rdata_q <= rd_value;
    end
  end

  // RESP sits exactly RD_LAT cycles after ISSUE, so reg_rdata is consumed directly there.
  assign rd_value     = op_oor ? '0 : reg_rdata;
  assign resp_i2c_rd  = (state == ST_RESP) && (owner == REQ_I2C) && !op_we;
  assign resp_host    = (state == ST_RESP) && (owner == REQ_HOST);
  assign resp_host_rd = resp_host && !op_we;
  assign free         = (state == ST_RESP) && (owner == REQ_I2C);

  assign i2c_rvalid = resp_i2c_rd;
  assign i2c_rdata  = resp_i2c_rd ? rd_value : i2c_rdata_q;
  assign host_ack   = resp_host;
  assign host_rdata = resp_host_rd ? rd_value : host_rdata_q;
  assign addr_err   = op_oor && (resp_i2c_rd || resp_host);

  assign reg_wen   = (state == ST_ISSUE) && op_we && !op_oor;
  assign reg_ren   = (state == ST_ISSUE) && !op_we && !op_oor;
  assign reg_addr  = op_addr;
  assign reg_wdata = op_wdata;

endmodule

// File: tb/tb_i2c_reg_arbiter.sv
// Scoreboard bench for i2c_reg_arbiter with a transaction-level arbitration model.
module tb_i2c_reg_arbiter;

  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned RD_LAT   = 2;

  logic       sys_clk = 1'b0;
  logic       reset_n;
  logic       i2c_wen, i2c_ren;
  logic [7:0] i2c_addr, i2c_wdata, i2c_rdata;
  logic       i2c_rvalid, i2c_ovf;
  logic       host_req, host_we;
  logic [7:0] host_addr, host_wdata, host_rdata;
  logic       host_ack, addr_err;
  logic       reg_wen, reg_ren;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 sys_clk = ~sys_clk;

  i2c_reg_arbiter #(
    .ADDR_W   (8),
    .DATA_W   (8),
    .NUM_REGS (NUM_REGS),
    .RD_LAT   (RD_LAT)
  ) dut (
    .sys_clk    (sys_clk),
    .reset_n    (reset_n),
    .i2c_wen    (i2c_wen),
    .i2c_ren    (i2c_ren),
    .i2c_addr   (i2c_addr),
    .i2c_wdata  (i2c_wdata),
    .i2c_rdata  (i2c_rdata),
    .i2c_rvalid (i2c_rvalid),
    .i2c_ovf    (i2c_ovf),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .addr_err   (addr_err),
    .reg_wen    (reg_wen),
    .reg_ren    (reg_ren),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata)
  );

  // Register-file stub: data appears RD_LAT cycles after reg_ren, junk otherwise.
  logic [7:0] mem   [256] = '{default: 8'h00};
  logic [7:0] rpipe [RD_LAT];
  always @(posedge sys_clk) begin
    if (reg_wen) mem[reg_addr] <= reg_wdata;
    rpipe[0] <= reg_ren ? mem[reg_addr] : 8'hEE;
    for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign reg_rdata = rpipe[RD_LAT-1];

  typedef struct { bit host; bit we; logic [7:0] data; bit err; int cyc; } exp_resp_t;
  typedef struct { bit we; logic [7:0] addr; logic [7:0] wdata; int cyc; } exp_strb_t;
  exp_resp_t resp_q[$];
  exp_strb_t strb_q[$];

  // Reference model: serial server, one-deep I2C slot, contents in model_mem.
  logic [7:0] model_mem [256] = '{default: 8'h00};
  bit         m_busy, m_owner_host, m_slot, m_s_we, m_ovf, m_prio_host;
  logic [7:0] m_s_addr, m_s_wdata;
  int         m_resp_cyc;

  always @(posedge sys_clk) begin
    if (!reset_n) begin
      m_busy = 0; m_slot = 0; m_ovf = 0; m_prio_host = 0; m_owner_host = 0;
      resp_q.delete();
      strb_q.delete();
    end else begin
      bit         idle_now, take_host, we, oor;
      logic [7:0] a, d;
      int         lat;
      idle_now = !m_busy;
      if (m_busy && cyc == m_resp_cyc) begin
        m_busy = 0;
        if (!m_owner_host) m_slot = 0;
      end
      if (i2c_wen || i2c_ren) begin
        if (m_slot) m_ovf = 1;
        else begin
          m_slot = 1; m_s_we = i2c_wen; m_s_addr = i2c_addr; m_s_wdata = i2c_wdata;
        end
        if (i2c_wen && i2c_ren) m_ovf = 1;
      end
      if (idle_now && (m_slot || host_req)) begin
`ifdef ARB_RR_EN
        take_host = host_req && (!m_slot || m_prio_host);
        m_prio_host = !take_host;
`else
        take_host = host_req && !m_slot;
`endif
        we  = take_host ? host_we    : m_s_we;
        a   = take_host ? host_addr  : m_s_addr;
        d   = take_host ? host_wdata : m_s_wdata;
        oor = (a >= NUM_REGS);
        lat = we ? 2 : 1 + RD_LAT;
        m_busy = 1; m_owner_host = take_host; m_resp_cyc = cyc + lat;
        if (!oor) begin
          strb_q.push_back('{we: we, addr: a, wdata: d, cyc: cyc + 1});
          if (we) model_mem[a] = d;
        end
        if (take_host || !we)
          resp_q.push_back('{host: take_host, we: we, data: (oor ? 8'h00 : model_mem[a]),
                             err: oor, cyc: cyc + lat});
      end
    end
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (reset_n) begin
      if (i2c_rvalid || host_ack) begin
        chk("resp_single", 32'(i2c_rvalid & host_ack), 0);
        chk("resp_pending", 32'(resp_q.size() != 0), 1);
        if (resp_q.size() != 0) begin
          exp_resp_t er;
          er = resp_q.pop_front();
          chk("resp_who", 32'(host_ack), 32'(er.host));
          chk("resp_cycle", cyc, er.cyc);
          chk("resp_err", 32'(addr_err), 32'(er.err));
          if (!er.we) chk("resp_data", er.host ? host_rdata : i2c_rdata, er.data);
        end
      end else if (addr_err) begin
        chk("addr_err_stray", 32'(addr_err), 0);
      end
      if (reg_wen || reg_ren) begin
        chk("strobe_pending", 32'(strb_q.size() != 0), 1);
        if (strb_q.size() != 0) begin
          exp_strb_t es;
          es = strb_q.pop_front();
          chk("strobe_wen", 32'(reg_wen), 32'(es.we));
          chk("strobe_ren", 32'(reg_ren), 32'(!es.we));
          chk("strobe_addr", reg_addr, es.addr);
          chk("strobe_cycle", cyc, es.cyc);
          if (es.we) chk("strobe_wdata", reg_wdata, es.wdata);
        end
      end
      chk("ovf", 32'(i2c_ovf), 32'(m_ovf));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge sys_clk); #1; end
  endtask

  task automatic i2c_pulse(input bit wen, input bit ren, input logic [7:0] a, input logic [7:0] d);
    i2c_wen = wen; i2c_ren = ren; i2c_addr = a; i2c_wdata = d;
    tick(1);
    i2c_wen = 0; i2c_ren = 0;
  endtask

  task automatic host_xfer(input bit we, input logic [7:0] a, input logic [7:0] d);
    int n;
    n = 0;
    host_req = 1; host_we = we; host_addr = a; host_wdata = d;
    do begin tick(1); n++; end while (!host_ack && n < 40);
    chk("host_ack_seen", 32'(host_ack), 1);
    host_req = 0;
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, "_strobes"}, {28'd0, reg_wen, reg_ren, i2c_rvalid, host_ack}, 0);
    chk({tag, "_flags"}, {30'd0, addr_err, i2c_ovf}, 0);
    chk({tag, "_rdata"}, {16'd0, i2c_rdata, host_rdata}, 0);
    chk({tag, "_regbus"}, {16'd0, reg_addr, reg_wdata}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 0;
    i2c_wen = 0; i2c_ren = 0; i2c_addr = '0; i2c_wdata = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    tick(3);
    outputs_zero("reset");
    @(negedge sys_clk); reset_n = 1;
    tick(1);

    // I2C writes (one out of range), then read back
    i2c_pulse(1, 0, 8'hC1, 8'h55); tick(4);
    i2c_pulse(1, 0, 8'h01, 8'h55); tick(4);
    i2c_pulse(0, 1, 8'h01, 8'h00); tick(6);

    // host write then read
    host_xfer(1, 8'h03, 8'hA5);
    host_xfer(0, 8'h03, 8'h00);
    tick(2);

    // simultaneous I2C read and host read
    fork
      i2c_pulse(0, 1, 8'h02, 8'h00);
      host_xfer(0, 8'h02, 8'h00);
    join
    tick(6);

    // two I2C pulses while host access in flight: second dropped
    fork
      host_xfer(0, 8'h03, 8'h00);
      begin
        tick(1); i2c_pulse(0, 1, 8'h03, 8'h00);
        tick(1); i2c_pulse(1, 0, 8'h04, 8'h77);
      end
    join
    tick(8);
    chk("ovf_sticky", 32'(i2c_ovf), 1);

    // out-of-range host read
    host_xfer(0, 8'h09, 8'h00);
    tick(2);

    // reset while the read sits in WAIT
    begin
      int n;
      n = 0;
      host_req = 1; host_we = 0; host_addr = 8'h03;
      do begin tick(1); n++; end while (!reg_ren && n < 20);
      chk("abort_ren_seen", 32'(reg_ren), 1);
      tick(1);
      #2 reset_n = 0;
      host_req = 0;
      #1 outputs_zero("abort");
      tick(2);
      @(negedge sys_clk); reset_n = 1;
      tick(4);
      chk("abort_no_ack", 32'(host_ack), 0);
      outputs_zero("after_abort");
    end

    // randomized concurrent traffic
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            bit both;
            both = ($urandom_range(0, 15) == 0);
            i2c_wen = both | $urandom_range(0, 1);
            i2c_ren = both | !i2c_wen;
            i2c_addr = 8'($urandom_range(0, 11));
            i2c_wdata = 8'($urandom);
          end else begin
            i2c_wen = 0; i2c_ren = 0;
          end
          tick(1);
        end
        i2c_wen = 0; i2c_ren = 0;
      end
      begin
        for (int i = 0; i < 60; i++) begin
          tick($urandom_range(0, 3));
          host_xfer(1'($urandom_range(0, 1)), 8'($urandom_range(0, 11)), 8'($urandom));
        end
      end
    join

    for (int i = 0; i < 300 && (resp_q.size() != 0 || strb_q.size() != 0 || m_busy); i++) tick(1);
    chk("drain_empty", resp_q.size() + strb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
